// File: rtl/decoder_3x8.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : decoder_3x8
// Description : Registered 3-to-8 one-hot decoder with enable, plus valid
//               flag, captured select and saturating enabled-decode counter.
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module decoder_3x8 #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   input  logic             en,
   input  logic             clr,
   output logic             d0,
   output logic             d1,
   output logic             d2,
   output logic             d3,
   output logic             d4,
   output logic             d5,
   output logic             d6,
   output logic             d7,
   output logic             valid,
   output logic [2:0]       sel,
   output logic [CNT_W-1:0] hit_cnt
);

   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [2:0]       w_s;
   logic [7:0]       w_onehot;
   logic [7:0]       r_d;
   logic             r_valid;
   logic [2:0]       r_sel;
   logic [CNT_W-1:0] r_cnt;

   assign w_s = {a, b, c};

   // A case decode (rather than a shift) lets unknown select bits fall into
   // the default arm, so X/Z on the select never raises any line.
   always_comb begin
      w_onehot = 8'h00;
      case (w_s)
         3'd0:    w_onehot = 8'h01;
         3'd1:    w_onehot = 8'h02;
         3'd2:    w_onehot = 8'h04;
         3'd3:    w_onehot = 8'h08;
         3'd4:    w_onehot = 8'h10;
         3'd5:    w_onehot = 8'h20;
         3'd6:    w_onehot = 8'h40;
         3'd7:    w_onehot = 8'h80;
         default: w_onehot = 8'h00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_d     <= 8'h00;
         r_valid <= 1'b0;
         r_sel   <= 3'b000;
         r_cnt   <= '0;
      end else begin
         r_d     <= en ? w_onehot : 8'h00;
         r_valid <= en;
         if (en) begin
            r_sel <= w_s;
         end
         // Clear wins over counting the same cycle's decode.
         if (clr) begin
            r_cnt <= '0;
         end else if (en && (r_cnt != c_cnt_max)) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

   assign d0      = r_d[0];
   assign d1      = r_d[1];
   assign d2      = r_d[2];
   assign d3      = r_d[3];
   assign d4      = r_d[4];
   assign d5      = r_d[5];
   assign d6      = r_d[6];
   assign d7      = r_d[7];
   assign valid   = r_valid;
   assign sel     = r_sel;
   assign hit_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decoder_3x8.sv
`default_nettype none
//-----------------------------------------------------------------------------
// Module      : tb_decoder_3x8
// Description : Directed self-checking bench for decoder_3x8 (default and
//               narrow-counter instances).
// Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_decoder_3x8;

   logic       clk;
   logic       rst_n;
   logic       a, b, c;
   logic       en, clr;
   logic       en2, clr2;
   logic       d0, d1, d2, d3, d4, d5, d6, d7;
   logic       valid;
   logic [2:0] sel;
   logic [7:0] hit_cnt;
   logic       n_d0, n_d1, n_d2, n_d3, n_d4, n_d5, n_d6, n_d7;
   logic       n_valid;
   logic [2:0] n_sel;
   logic [1:0] n_hit_cnt;
   logic [7:0] d_vec;

   int checks   = 0;
   int failures = 0;

   assign d_vec = {d7, d6, d5, d4, d3, d2, d1, d0};

   decoder_3x8 #(.CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en), .clr(clr),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7),
      .valid(valid), .sel(sel), .hit_cnt(hit_cnt)
   );

   // Narrow counter instance with its own enable/clear to exercise saturation.
   decoder_3x8 #(.CNT_W(2)) u_dut_narrow (
      .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .en(en2), .clr(clr2),
      .d0(n_d0), .d1(n_d1), .d2(n_d2), .d3(n_d3), .d4(n_d4), .d5(n_d5),
      .d6(n_d6), .d7(n_d7), .valid(n_valid), .sel(n_sel), .hit_cnt(n_hit_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_sel(input logic [2:0] v);
      {a, b, c} = v;
   endtask

   initial begin
      logic [7:0] exp_d [8];
      exp_d = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

      rst_n = 1'b0; a = 1'b1; b = 1'b0; c = 1'b0;
      en = 1'b0; clr = 1'b0; en2 = 1'b0; clr2 = 1'b0;
      tick(); tick();
      check("rst_hold_d",   {24'h0, d_vec}, 32'h0);
      check("rst_hold_cnt", {24'h0, hit_cnt}, 32'h0);
      rst_n = 1'b1;
      tick();
      check("rst_d",     {24'h0, d_vec}, 32'h0);
      check("rst_valid", {31'h0, valid}, 32'h0);
      check("rst_sel",   {29'h0, sel}, 32'h0);
      check("rst_cnt",   {24'h0, hit_cnt}, 32'h0);

      // Disabled with s=4 for three cycles
      set_sel(3'b100); en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("dis_d",     {24'h0, d_vec}, 32'h0);
         check("dis_valid", {31'h0, valid}, 32'h0);
         check("dis_sel",   {29'h0, sel}, 32'h0);
         check("dis_cnt",   {24'h0, hit_cnt}, 32'h0);
      end

      // Back-to-back sweep of all select values
      en = 1'b1;
      for (int s = 0; s < 8; s++) begin
         set_sel(3'(s));
         tick();
         check("sweep_d",     {24'h0, d_vec}, {24'h0, exp_d[s]});
         check("sweep_valid", {31'h0, valid}, 32'h1);
         check("sweep_sel",   {29'h0, sel}, s);
      end
      check("sweep_cnt", {24'h0, hit_cnt}, 32'd8);

      // Enable drop after s=3, then select change while disabled
      set_sel(3'd3); en = 1'b1;
      tick();
      check("drop_pre_d", {24'h0, d_vec}, 32'h08);
      en = 1'b0;
      tick();
      check("drop_d",     {24'h0, d_vec}, 32'h0);
      check("drop_valid", {31'h0, valid}, 32'h0);
      check("drop_sel",   {29'h0, sel}, 32'd3);
      check("drop_cnt",   {24'h0, hit_cnt}, 32'd9);
      set_sel(3'd6);
      tick();
      check("dis_chg_d",   {24'h0, d_vec}, 32'h0);
      check("dis_chg_sel", {29'h0, sel}, 32'd3);

      // clr has priority over an enabled decode but does not block decode
      set_sel(3'd2); en = 1'b1; clr = 1'b1;
      tick();
      check("clr_cnt",   {24'h0, hit_cnt}, 32'd0);
      check("clr_d",     {24'h0, d_vec}, 32'h04);
      check("clr_valid", {31'h0, valid}, 32'h1);
      check("clr_sel",   {29'h0, sel}, 32'd2);
      clr = 1'b0;
      tick();
      check("post_clr_cnt", {24'h0, hit_cnt}, 32'd1);

      // Saturation on the 2-bit counter instance
      check("narrow_start", {30'h0, n_hit_cnt}, 32'd0);
      en2 = 1'b1;
      tick(); check("narrow_c1", {30'h0, n_hit_cnt}, 32'd1);
      tick(); check("narrow_c2", {30'h0, n_hit_cnt}, 32'd2);
      tick(); check("narrow_c3", {30'h0, n_hit_cnt}, 32'd3);
      tick(); check("narrow_c4", {30'h0, n_hit_cnt}, 32'd3);
      tick(); check("narrow_c5", {30'h0, n_hit_cnt}, 32'd3);
      clr2 = 1'b1;
      tick(); check("narrow_clr", {30'h0, n_hit_cnt}, 32'd0);
      clr2 = 1'b0; en2 = 1'b0;

      // Asynchronous reset between edges
      set_sel(3'd7); en = 1'b1;
      tick();
      check("pre_async_d", {24'h0, d_vec}, 32'h80);
      #2 rst_n = 1'b0;
      #1;
      check("async_d",     {24'h0, d_vec}, 32'h0);
      check("async_valid", {31'h0, valid}, 32'h0);
      check("async_sel",   {29'h0, sel}, 32'd0);
      check("async_cnt",   {24'h0, hit_cnt}, 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("rel_d",   {24'h0, d_vec}, 32'h80);
      check("rel_sel", {29'h0, sel}, 32'd7);
      check("rel_cnt", {24'h0, hit_cnt}, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decoder_3x8.md
Name: decoder_3x8

Overview:
- Registered 3-to-8 line decoder with active-high enable.
- Select input {a,b,c}, with a as the MSB, drives exactly one of d0..d7 high when enabled. All outputs are low when disabled.
- Also provides a valid flag, a captured select index and a saturating count of enabled decodes, for status/debug use.
- Sits between control logic and one-hot consumers such as chip-selects or mux enables.

Parameters:
- CNT_W, 8: width of the enabled-decode counter hit_cnt; legal range is 1 or more.

Ports:
- clk  input  1  rising-edge system clock
- rst_n  input  1  asynchronous, active-low reset
- a  input  1  select bit 2 (MSB)
- b  input  1  select bit 1
- c  input  1  select bit 0 (LSB)
- en  input  1  decode enable, active high
- clr  input  1  synchronous clear of hit_cnt, active high
- d0..d7  output  1 each  decoded one-hot lines; dk is high for select value k
- valid  output  1  high when the d outputs reflect an enabled decode
- sel  output  3  last enabled select value {a,b,c}
- hit_cnt  output  CNT_W  saturating count of cycles sampled with en=1

Behaviour:
- One clock and one reset. Reset is asynchronous and active-low.
- While rst_n=0: d0..d7=0, valid=0, sel=3'b000, hit_cnt=0, all immediately and independent of clk. Release takes effect at the next rising edge.
- Latency is 1 cycle. Inputs are sampled on the rising clk edge, and outputs change only on that edge (or on reset).
- Let s={a,b,c}, so s=0..7.
- Each edge, every k in 0..7 gets dk <= en & (s==k).
- With en=1, exactly one dk is 1 after the edge.
- With en=0, all dk are 0 after the edge. This holds regardless of s, including when s changes while disabled.
- Outputs are never multi-hot. Any X or Z on a, b or c while en=1 shall drive no dk high (treat as not matching).
- valid <= en each edge.
- sel <= s when en=1; sel holds its value when en=0.
- hit_cnt, per edge:
  - if clr=1 → 0; clr has priority and that cycle's enabled decode is not counted;
  - else if en=1 and hit_cnt < 2^CNT_W-1 → hit_cnt+1;
  - else hold.
  - Saturates at all-ones and does not wrap.
- clr does not affect d0..d7, valid or sel.
- Back-to-back select changes with en=1 produce a new one-hot output every cycle with no gaps or glitches on the registered outputs.
- Reset asserted mid-operation clears all outputs at once. The counter restarts from 0 after release.
- No other state: no internal FSM beyond the registers listed.

Test Plan:
- Reset: hold rst_n=0 with a=1,b=0,c=0,en=0, then release and clock → d0..d7 all 0, valid=0, sel=0, hit_cnt=0.
- Disabled: en=0, s=3'b100 for 3 cycles → all d=0, valid=0, sel unchanged, hit_cnt unchanged.
- Sweep: en=1, s=0..7 on consecutive cycles → one cycle after each s, only d[s]=1 (e.g. s=5 gives d5=1, others 0), valid=1, sel=s. After 8 cycles hit_cnt=8.
- Enable drop: from en=1, s=3 (d3=1), drive en=0 → next edge all d=0, valid=0, sel stays 3.
- Counter: CNT_W=2, en=1 for 5 cycles → hit_cnt goes 1,2,3,3,3. Then clr=1 with en=1 → hit_cnt=0.
- Async reset mid-run: en=1, s=7, assert rst_n=0 between edges → d7 and all other outputs go to 0 without waiting for clk.
